// File: rtl/fsbm_mb_sched.sv
// fsbm_mb_sched
//   Macroblock-level sequencer for the full-search block-matching array.
//   For each macroblock it requests source data, holds en_init to the
//   24-cycle controller for INIT_CYCLES, runs ROWS_PER_MB row periods of
//   ROW_PERIOD cycles, drains the PE pipeline, then moves to the next
//   macroblock until the latched frame length is reached.
//
//   Optional feature macro: SCHED_ABORT_EN (adds abort / abort_ack).
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   start      frame start request, sampled only in IDLE
//   num_mb     macroblocks in frame, latched when start is accepted
//   src_valid  source memory has the next macroblock ready
//   abort      (SCHED_ABORT_EN) return to IDLE from any busy state
//   abort_ack  (SCHED_ABORT_EN) 1-cycle acknowledge of an abort
//   src_req    high while waiting for source data
//   en_init    init enable to the cycle controller
//   busy       high in every state except IDLE
//   mb_idx     current macroblock index, 0-based
//   row_idx    current row period within RUN (saturates at the last row)
//   mb_done    1-cycle pulse on the last drain cycle of each macroblock
//   done       1-cycle pulse when the frame completes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start
// WAIT_SRC | src_req high until source memory reports the macroblock ready
// INIT     | en_init high for INIT_CYCLES
// RUN      | ROWS_PER_MB row periods of ROW_PERIOD cycles
// DRAIN    | PE pipeline drain; mb_done on the last cycle

module fsbm_mb_sched #(
    parameter int INIT_CYCLES  = 73,
    parameter int ROW_PERIOD   = 24,
    parameter int ROWS_PER_MB  = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int MB_CNT_W     = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MB_CNT_W-1:0] num_mb,
    input  logic                src_valid,
`ifdef SCHED_ABORT_EN
    input  logic                abort,
    output logic                abort_ack,
`endif
    output logic                src_req,
    output logic                en_init,
    output logic                busy,
    output logic [MB_CNT_W-1:0] mb_idx,
    output logic [4:0]          row_idx,
    output logic                mb_done,
    output logic                done
);

    // One shared phase down-counter covers INIT, each row period and DRAIN.
    localparam int CNT_MAX0 = (INIT_CYCLES > ROW_PERIOD) ? INIT_CYCLES : ROW_PERIOD;
    localparam int CNT_MAX  = (CNT_MAX0 > DRAIN_CYCLES) ? CNT_MAX0 : DRAIN_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SRC,
        S_INIT,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [MB_CNT_W-1:0] num_mb_q, num_mb_n;
    logic [MB_CNT_W-1:0] mb_idx_n;
    logic [4:0]          row_idx_n;
    logic                src_req_n, en_init_n, busy_n, mb_done_n, done_n;
    logic                mb_last;
`ifdef SCHED_ABORT_EN
    logic                abort_ack_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            num_mb_q <= '0;
            mb_idx   <= '0;
            row_idx  <= '0;
            src_req  <= 1'b0;
            en_init  <= 1'b0;
            busy     <= 1'b0;
            mb_done  <= 1'b0;
            done     <= 1'b0;
`ifdef SCHED_ABORT_EN
            abort_ack <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            num_mb_q <= num_mb_n;
            mb_idx   <= mb_idx_n;
            row_idx  <= row_idx_n;
            src_req  <= src_req_n;
            en_init  <= en_init_n;
            busy     <= busy_n;
            mb_done  <= mb_done_n;
            done     <= done_n;
`ifdef SCHED_ABORT_EN
            abort_ack <= abort_ack_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        num_mb_n  = num_mb_q;
        mb_idx_n  = mb_idx;
        row_idx_n = row_idx;
        done_n    = 1'b0;
        mb_last   = (mb_idx == num_mb_q - MB_CNT_W'(1));

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_mb != '0) begin
                        num_mb_n  = num_mb;
                        mb_idx_n  = '0;
                        row_idx_n = '0;
                        state_n   = S_WAIT_SRC;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            S_WAIT_SRC: begin
                if (src_valid) begin
                    state_n = S_INIT;
                    cnt_n   = CNT_W'(INIT_CYCLES - 1);
                end
            end
            S_INIT: begin
                if (cnt == '0) begin
                    state_n = S_RUN;
                    cnt_n   = CNT_W'(ROW_PERIOD - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    // Last row leaves row_idx at its final value (saturates).
                    if (row_idx == 5'(ROWS_PER_MB - 1)) begin
                        state_n = S_DRAIN;
                        cnt_n   = CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        row_idx_n = row_idx + 5'd1;
                        cnt_n     = CNT_W'(ROW_PERIOD - 1);
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == '0) begin
                    row_idx_n = '0;
                    if (mb_last) begin
                        state_n = S_IDLE;
                    end else begin
                        mb_idx_n = mb_idx + MB_CNT_W'(1);
                        state_n  = S_WAIT_SRC;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Registered pulses are decided from the state being entered, so
        // mb_done/done are visible during the final drain cycle itself.
        mb_done_n = (state_n == S_DRAIN) && (cnt_n == '0);
        done_n    = done_n | (mb_done_n & mb_last);

`ifdef SCHED_ABORT_EN
        abort_ack_n = 1'b0;
        if (abort && (state != S_IDLE)) begin
            state_n     = S_IDLE;
            cnt_n       = '0;
            row_idx_n   = '0;
            mb_done_n   = 1'b0;
            done_n      = 1'b0;
            abort_ack_n = 1'b1;
        end
`endif

        src_req_n = (state_n == S_WAIT_SRC);
        en_init_n = (state_n == S_INIT);
        busy_n    = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_fsbm_mb_sched.sv
module tb_fsbm_mb_sched;
    localparam int W = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  num_mb = '0;
    logic          src_valid = 1'b0;
    logic          src_req, en_init, busy, mb_done, done;
    logic [W-1:0]  mb_idx;
    logic [4:0]    row_idx;
`ifdef SCHED_ABORT_EN
    logic          abort = 1'b0;
    logic          abort_ack;
`endif

    int checks = 0;
    int errors = 0;
    int dly[8];

    always #5 clk = ~clk;

    fsbm_mb_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_mb    (num_mb),
        .src_valid (src_valid),
`ifdef SCHED_ABORT_EN
        .abort     (abort),
        .abort_ack (abort_ack),
`endif
        .src_req   (src_req),
        .en_init   (en_init),
        .busy      (busy),
        .mb_idx    (mb_idx),
        .row_idx   (row_idx),
        .mb_done   (mb_done),
        .done      (done)
    );

    wire [21:0] obs = {src_req, en_init, busy, mb_done, done, mb_idx, row_idx};

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs r cycles after macroblock k began (r=0 is the cycle
    // after the edge entering WAIT_SRC), with src_valid withheld for d cycles.
    // Phase lengths: WAIT 1+d, INIT 73, RUN 32*24=768, DRAIN 4.
    function automatic logic [21:0] model(input int r, input int d, input int k, input bit last);
        bit sr, ei, mbd, dn;
        int row;
        sr = 0; ei = 0; mbd = 0; dn = 0; row = 0;
        if (r <= d) sr = 1;
        else if (r <= d + 73) ei = 1;
        else if (r <= d + 73 + 768) row = (r - d - 74) / 24;
        else begin
            row = 31;
            if (r == d + 845) begin
                mbd = 1;
                dn  = last;
            end
        end
        return {sr, ei, 1'b1, mbd, dn, W'(k), 5'(row)};
    endfunction

    // stop_mode: 0 run to completion, 1 reset pulse, 2 abort, at (stop_k, stop_r)
    task automatic run_frame(input int n, input int stop_mode, input int stop_k, input int stop_r);
        @(posedge clk); #1;
        start  = 1'b1;
        num_mb = W'(n);
        src_valid = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r <= dly[k] + 845; r++) begin
                @(posedge clk); #1;
                chk($sformatf("n%0d_mb%0d_r%0d", n, k, r), 32'(obs), 32'(model(r, dly[k], k, k == n - 1)));
                // start/num_mb while busy must be ignored
                start  = 1'($urandom);
                num_mb = W'($urandom);
                if (r < dly[k]) src_valid = 1'b0;
                else if (r == dly[k]) src_valid = 1'b1;
                else src_valid = 1'($urandom);
                if (stop_mode != 0 && k == stop_k && r == stop_r) begin
                    if (stop_mode == 1) rst_n = 1'b0;
`ifdef SCHED_ABORT_EN
                    else abort = 1'b1;
`endif
                    @(posedge clk); #1;
                    start = 1'b0;
                    if (stop_mode == 1) begin
                        chk("reset_mid_frame", 32'(obs), 32'd0);
                        rst_n = 1'b1;
                    end
`ifdef SCHED_ABORT_EN
                    else begin
                        chk("abort_outputs", {26'd0, src_req, en_init, busy, mb_done, done, abort_ack}, 32'b000001);
                        abort = 1'b0;
                        @(posedge clk); #1;
                        chk("abort_ack_pulse", {30'd0, abort_ack, busy}, 32'd0);
                    end
`endif
                    return;
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("n%0d_frame_end", n), {27'd0, busy, done, mb_done, en_init, src_req}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dly[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs), 32'd0);
        rst_n = 1'b1;

        // T1 single macroblock, source always ready
        run_frame(1, 0, 0, 0);

        // T2 three macroblocks back to back
        run_frame(3, 0, 0, 0);

        // T3 source withheld 50 cycles before MB1
        dly[1] = 50;
        run_frame(2, 0, 0, 0);
        dly[1] = 0;

        // T4 empty frame
        @(posedge clk); #1;
        start = 1'b1; num_mb = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("empty_done", {29'd0, done, busy, en_init}, 32'b100);
        @(posedge clk); #1;
        chk("empty_after", {29'd0, done, busy, en_init}, 32'd0);

        // T5 reset during RUN row 10, then a fresh frame
        run_frame(1, 1, 0, 74 + 10 * 24 + 5);
        run_frame(1, 0, 0, 0);

`ifdef SCHED_ABORT_EN
        // T6 abort in INIT cycle 20, then a new start; abort in IDLE ignored
        run_frame(2, 2, 0, 20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_ignored", {30'd0, abort_ack, busy}, 32'd0);
        run_frame(1, 0, 0, 0);
`endif

        // Randomized frames with random source delays
        for (int f = 0; f < 3; f++) begin
            int n;
            n = int'($urandom_range(3, 1));
            for (int i = 0; i < 8; i++) dly[i] = int'($urandom_range(15, 0));
            run_frame(n, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
